// File: rtl/memory_island_wide_responder.sv
// memory_island_wide_responder: round-robin two-port front end for one wide single-port SRAM bank.
// Latency: MemoryLatency cycles from grant to rvalid; one grant and one response per cycle sustained.
// Backpressure: requests stall via wide_gnt_o only; responses have no backpressure and cannot be stalled.
//
// Ports:
//   clk_i, rst_ni                 single clock, synchronous active-low reset
//   wide_req_i/gnt_o/addr_i/we_i  two request ports (0 = read port, 1 = write port; either may read or write)
//   wide_wdata_i/strb_i           write data and byte enables, sampled only in the grant cycle
//   wide_rvalid_o/rdata_o         per-port response; rdata is '0 for writes and on the idle port
//   sram_*                        single-port SRAM macro; read data arrives one cycle after sram_req_o
//   conflict_cnt_o                saturating count of cycles with both ports requesting
//
// Build option: define MEMORY_ISLAND_RESPONDER_CONFLICT_CNT_EN to enable the conflict counter;
// without it conflict_cnt_o is tied to zero.

module memory_island_wide_responder #(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned WideDataWidth = 64,
  parameter int unsigned MemoryLatency = 2,
  parameter int unsigned NumWords      = 1024,
  localparam int unsigned WideStrbWidth = WideDataWidth / 8,
  localparam int unsigned IdxWidth      = $clog2(NumWords),
  localparam int unsigned OffWidth      = $clog2(WideStrbWidth)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [1:0]                          wide_req_i,
  output logic [1:0]                          wide_gnt_o,
  input  logic [1:0][AddrWidth-1:0]           wide_addr_i,
  input  logic [1:0]                          wide_we_i,
  input  logic [1:0][WideDataWidth-1:0]       wide_wdata_i,
  input  logic [1:0][WideStrbWidth-1:0]       wide_strb_i,
  output logic [1:0]                          wide_rvalid_o,
  output logic [1:0][WideDataWidth-1:0]       wide_rdata_o,
  output logic                                sram_req_o,
  output logic                                sram_we_o,
  output logic [IdxWidth-1:0]                 sram_addr_o,
  output logic [WideDataWidth-1:0]            sram_wdata_o,
  output logic [WideStrbWidth-1:0]            sram_be_o,
  input  logic [WideDataWidth-1:0]            sram_rdata_i,
  output logic [31:0]                         conflict_cnt_o
);

  // Per-access bookkeeping that travels alongside the SRAM read latency.
  typedef struct packed {
    logic vld;
    logic port;
    logic we;
  } rsp_t;

  logic                     prio_q;
  logic [1:0]               gnt;
  logic                     any_gnt;
  logic                     sel;
  rsp_t                     pipe_in;
  rsp_t                     pipe_q [MemoryLatency];
  rsp_t                     rsp_out;
  logic [WideDataWidth-1:0] rsp_data;
  logic                     rsp_vld;
  logic [WideDataWidth-1:0] rsp_rdata;

  // Only the word-index slice of the byte address reaches the SRAM; the
  // remaining bits are intentionally ignored (no range checking).
  logic unused_addr_bits;
  assign unused_addr_bits = ^wide_addr_i;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester always wins; on contention prio_q decides.
  // Reset overrides everything so nothing reaches the SRAM while in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt = 2'b00;
    if (rst_ni) begin
      case (wide_req_i)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign wide_gnt_o = gnt;
  assign any_gnt    = |gnt;
  assign sel        = gnt[1];

  // Only contested grants rotate priority; the winner of a contest always
  // becomes the loser next time, so the pointer simply toggles.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prio_q <= 1'b0;
    end else if (wide_req_i == 2'b11) begin
      prio_q <= ~prio_q;
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM drive: granted port passes straight through; everything is zeroed
  // when idle so the macro pins are quiet between accesses.
  // ---------------------------------------------------------------------------
  assign sram_req_o   = any_gnt;
  assign sram_we_o    = any_gnt & wide_we_i[sel];
  assign sram_addr_o  = any_gnt ? wide_addr_i[sel][OffWidth +: IdxWidth] : '0;
  assign sram_wdata_o = any_gnt ? wide_wdata_i[sel] : '0;
  assign sram_be_o    = any_gnt ? wide_strb_i[sel] : '0;

  // ---------------------------------------------------------------------------
  // Response tracking: stage 0 loads at the grant edge, the last stage is the
  // response cycle, giving exactly MemoryLatency cycles grant-to-rvalid.
  // ---------------------------------------------------------------------------
  always_comb begin
    pipe_in      = '0;
    pipe_in.vld  = any_gnt;
    pipe_in.port = sel;
    pipe_in.we   = sram_we_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MemoryLatency; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < MemoryLatency; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign rsp_out = pipe_q[MemoryLatency-1];

  // SRAM data is valid while stage 0 holds the access; data_q[k] stays aligned
  // with pipe_q[k+1]. These registers need no reset: the valid bits gate them.
  if (MemoryLatency == 1) begin : g_fwd
    assign rsp_data = sram_rdata_i;
  end else begin : g_dly
    logic [WideDataWidth-1:0] data_q [MemoryLatency-1];

    always_ff @(posedge clk_i) begin
      // Capture only real reads so the first stage stays still otherwise.
      if (pipe_q[0].vld && !pipe_q[0].we) begin
        data_q[0] <= sram_rdata_i;
      end
      for (int i = 1; i < MemoryLatency - 1; i++) begin
        data_q[i] <= data_q[i-1];
      end
    end

    assign rsp_data = data_q[MemoryLatency-2];
  end

  // Gating with rst_ni keeps every response output low for the whole time
  // reset is asserted, including the window before the clearing edge.
  assign rsp_vld   = rsp_out.vld & rst_ni;
  assign rsp_rdata = (rsp_vld && !rsp_out.we) ? rsp_data : '0;

  assign wide_rvalid_o[0] = rsp_vld & ~rsp_out.port;
  assign wide_rvalid_o[1] = rsp_vld &  rsp_out.port;
  assign wide_rdata_o[0]  = wide_rvalid_o[0] ? rsp_rdata : '0;
  assign wide_rdata_o[1]  = wide_rvalid_o[1] ? rsp_rdata : '0;

  // ---------------------------------------------------------------------------
  // Conflict counter: counts cycles in which one port was stalled by the other.
  // ---------------------------------------------------------------------------
`ifdef MEMORY_ISLAND_RESPONDER_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      conflict_cnt_q <= 32'h0;
    end else if ((wide_req_i == 2'b11) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_memory_island_wide_responder.sv
// tb_memory_island_wide_responder: directed and scoreboard checks of the wide responder.
// Three instances (MemoryLatency 2, 1, 4) share stimulus and one behavioural SRAM.
// Inputs change #1 after posedge; outputs are sampled on the negedge.

module tb_memory_island_wide_responder;

  localparam int NW = 1024;
  localparam logic [63:0] D   = 64'hDEAD_BEEF_0000_0005;
  localparam logic [63:0] WD0 = 64'hA5A5_A5A5_1234_5678;
  localparam logic [63:0] WD1 = 64'h1122_3344_5566_7788;
`ifdef MEMORY_ISLAND_RESPONDER_CONFLICT_CNT_EN
  localparam bit CC_EN = 1'b1;
`else
  localparam bit CC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             load_en;
  logic [1:0]       req, we;
  logic [1:0][31:0] addr;
  logic [1:0][63:0] wdata;
  logic [1:0][7:0]  strb;

  logic [1:0]       gnt    [3];
  logic [1:0]       rvalid [3];
  logic [1:0][63:0] rdata  [3];
  logic             sreq   [3];
  logic             swe    [3];
  logic [9:0]       saddr  [3];
  logic [63:0]      swdata [3];
  logic [7:0]       sbe    [3];
  logic [31:0]      ccnt   [3];
  logic [63:0]      srd;

  function automatic int lat(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    memory_island_wide_responder #(
      .AddrWidth    (32),
      .WideDataWidth(64),
      .MemoryLatency((g == 0) ? 2 : ((g == 1) ? 1 : 4)),
      .NumWords     (NW)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .wide_req_i    (req),
      .wide_gnt_o    (gnt[g]),
      .wide_addr_i   (addr),
      .wide_we_i     (we),
      .wide_wdata_i  (wdata),
      .wide_strb_i   (strb),
      .wide_rvalid_o (rvalid[g]),
      .wide_rdata_o  (rdata[g]),
      .sram_req_o    (sreq[g]),
      .sram_we_o     (swe[g]),
      .sram_addr_o   (saddr[g]),
      .sram_wdata_o  (swdata[g]),
      .sram_be_o     (sbe[g]),
      .sram_rdata_i  (srd),
      .conflict_cnt_o(ccnt[g])
    );
  end

  // Initial memory image: word 5 and words 16..31 are distinctive, rest all-ones.
  function automatic logic [63:0] init_word(input int i);
    if (i == 5) return D;
    if (i >= 16 && i < 32) return 64'h0123_4567_0000_0000 | 64'(i);
    return '1;
  endfunction

  // Behavioural single-port SRAM, read data one cycle after request.
  logic [63:0] mem [NW];
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < NW; i++) mem[i] <= init_word(i);
    end else if (sreq[0]) begin
      if (swe[0]) begin
        for (int b = 0; b < 8; b++)
          if (sbe[0][b]) mem[saddr[0]][8*b +: 8] <= swdata[0][8*b +: 8];
      end else begin
        srd <= mem[saddr[0]];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [31:0] a0, a1;
    logic [7:0]  s0, s1;
    logic [1:0]  gnt;
    logic        swe;
    logic [9:0]  saddr;
    logic [7:0]  sbe;
    logic [1:0]  rv;
    logic [63:0] rd0, rd1;
    int          cc;
  } vec_t;

  vec_t vec [18];

  // Scoreboard state for the latency sweep.
  logic [63:0] shadow [NW];
  logic        ring_v [3][8];
  logic        ring_p [3][8];
  logic [63:0] ring_d [3][8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_wd;
    logic [1:0]  eg;
    logic        prio_m;
    logic [31:0] a;
    logic [9:0]  w;
    logic [63:0] dat;
    int          p, slot;

    // -- vector table (MemoryLatency = 2 instance) --
    //           req    we     a0            a1        s0     s1     gnt    swe   saddr  sbe    rv     rd0                    rd1  cc
    vec[0]  = '{2'b11, 2'b00, 32'h28,       32'h28,   8'hFF, 8'hFF, 2'b01, 1'b0, 10'd5,  8'hFF, 2'b00, 64'h0,                 64'h0, 0};
    vec[1]  = '{2'b11, 2'b00, 32'h28,       32'h28,   8'hFF, 8'hFF, 2'b10, 1'b0, 10'd5,  8'hFF, 2'b00, 64'h0,                 64'h0, 1};
    vec[2]  = '{2'b11, 2'b00, 32'h28,       32'h28,   8'hFF, 8'hFF, 2'b01, 1'b0, 10'd5,  8'hFF, 2'b01, D,                     64'h0, 2};
    vec[3]  = '{2'b11, 2'b00, 32'h28,       32'h28,   8'hFF, 8'hFF, 2'b10, 1'b0, 10'd5,  8'hFF, 2'b10, 64'h0,                 D,     3};
    vec[4]  = '{2'b00, 2'b00, 32'h0,        32'h0,    8'h00, 8'h00, 2'b00, 1'b0, 10'd0,  8'h00, 2'b01, D,                     64'h0, 4};
    vec[5]  = '{2'b00, 2'b00, 32'h0,        32'h0,    8'h00, 8'h00, 2'b00, 1'b0, 10'd0,  8'h00, 2'b10, 64'h0,                 D,     4};
    vec[6]  = '{2'b00, 2'b00, 32'h0,        32'h0,    8'h00, 8'h00, 2'b00, 1'b0, 10'd0,  8'h00, 2'b00, 64'h0,                 64'h0, 4};
    vec[7]  = '{2'b10, 2'b10, 32'h0,        32'h40,   8'h00, 8'h0F, 2'b10, 1'b1, 10'd8,  8'h0F, 2'b00, 64'h0,                 64'h0, 4};
    vec[8]  = '{2'b01, 2'b00, 32'h40,       32'h0,    8'hFF, 8'h00, 2'b01, 1'b0, 10'd8,  8'hFF, 2'b00, 64'h0,                 64'h0, 4};
    vec[9]  = '{2'b00, 2'b00, 32'h0,        32'h0,    8'h00, 8'h00, 2'b00, 1'b0, 10'd0,  8'h00, 2'b10, 64'h0,                 64'h0, 4};
    vec[10] = '{2'b00, 2'b00, 32'h0,        32'h0,    8'h00, 8'h00, 2'b00, 1'b0, 10'd0,  8'h00, 2'b01, 64'hFFFF_FFFF_5566_7788, 64'h0, 4};
    vec[11] = '{2'b11, 2'b11, 32'h48,       32'h50,   8'hF0, 8'hFF, 2'b01, 1'b1, 10'd9,  8'hF0, 2'b00, 64'h0,                 64'h0, 4};
    vec[12] = '{2'b10, 2'b10, 32'h48,       32'h50,   8'hF0, 8'hFF, 2'b10, 1'b1, 10'd10, 8'hFF, 2'b00, 64'h0,                 64'h0, 5};
    vec[13] = '{2'b11, 2'b00, 32'h48,       32'h50,   8'hFF, 8'hFF, 2'b10, 1'b0, 10'd10, 8'hFF, 2'b01, 64'h0,                 64'h0, 5};
    vec[14] = '{2'b01, 2'b00, 32'h48,       32'h50,   8'hFF, 8'hFF, 2'b01, 1'b0, 10'd9,  8'hFF, 2'b10, 64'h0,                 64'h0, 6};
    vec[15] = '{2'b11, 2'b00, 32'hFFFF_E02F, 32'h48,  8'hFF, 8'hFF, 2'b01, 1'b0, 10'd5,  8'hFF, 2'b10, 64'h0,                 WD1,   6};
    vec[16] = '{2'b00, 2'b00, 32'h0,        32'h0,    8'h00, 8'h00, 2'b00, 1'b0, 10'd0,  8'h00, 2'b01, 64'hA5A5_A5A5_FFFF_FFFF, 64'h0, 7};
    vec[17] = '{2'b00, 2'b00, 32'h0,        32'h0,    8'h00, 8'h00, 2'b00, 1'b0, 10'd0,  8'h00, 2'b01, D,                     64'h0, 7};

    // -- reset with requests asserted: arbiter must be overridden --
    rst_n = 1'b0; load_en = 1'b1;
    req = 2'b11; we = 2'b11;
    addr[0] = 32'h28; addr[1] = 32'h40;
    wdata[0] = WD0; wdata[1] = WD1;
    strb[0] = 8'hFF; strb[1] = 8'hFF;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_gnt",      64'(gnt[0]), 64'h0);
    chk("rst_sram_req", 64'(sreq[0]), 64'h0);
    chk("rst_sram_we",  64'(swe[0]), 64'h0);
    chk("rst_sram_addr", 64'(saddr[0]), 64'h0);
    chk("rst_sram_wdata", swdata[0], 64'h0);
    chk("rst_sram_be",  64'(sbe[0]), 64'h0);
    chk("rst_rvalid",   64'(rvalid[0]), 64'h0);
    chk("rst_rdata0",   rdata[0][0], 64'h0);
    chk("rst_rdata1",   rdata[0][1], 64'h0);
    chk("rst_cnt",      64'(ccnt[0]), 64'h0);
    tick();
    load_en = 1'b0;
    rst_n   = 1'b1;

    // -- table-driven vectors --
    for (int i = 0; i < 18; i++) begin
      req = vec[i].req; we = vec[i].we;
      addr[0] = vec[i].a0; addr[1] = vec[i].a1;
      strb[0] = vec[i].s0; strb[1] = vec[i].s1;
      @(negedge clk);
      exp_wd = vec[i].gnt[0] ? WD0 : (vec[i].gnt[1] ? WD1 : 64'h0);
      chk($sformatf("row%0d_gnt", i), 64'(gnt[0]), 64'(vec[i].gnt));
      chk($sformatf("row%0d_sram", i), 64'({sreq[0], swe[0], saddr[0], sbe[0]}),
          64'({|vec[i].gnt, vec[i].swe, vec[i].saddr, vec[i].sbe}));
      chk($sformatf("row%0d_sram_wdata", i), swdata[0], exp_wd);
      chk($sformatf("row%0d_rvalid", i), 64'(rvalid[0]), 64'(vec[i].rv));
      chk($sformatf("row%0d_rdata0", i), rdata[0][0], vec[i].rd0);
      chk($sformatf("row%0d_rdata1", i), rdata[0][1], vec[i].rd1);
      chk($sformatf("row%0d_cnt", i), 64'(ccnt[0]), CC_EN ? 64'(vec[i].cc) : 64'h0);
      tick();
    end

    // -- back-to-back streaming: 16 reads on port 0 --
    for (int k = 0; k < 20; k++) begin
      if (k < 16) begin
        req = 2'b01; we = 2'b00; strb[0] = 8'hFF;
        addr[0] = 32'((16 + k) * 8);
      end else begin
        req = 2'b00;
      end
      @(negedge clk);
      if (k < 16) begin
        chk($sformatf("stream%0d_gnt", k), 64'(gnt[0]), 64'h1);
        chk($sformatf("stream%0d_addr", k), 64'(saddr[0]), 64'(16 + k));
      end
      chk($sformatf("stream%0d_rvalid", k), 64'(rvalid[0]), (k >= 2 && k < 18) ? 64'h1 : 64'h0);
      chk($sformatf("stream%0d_rdata", k), rdata[0][0], (k >= 2 && k < 18) ? init_word(16 + k - 2) : 64'h0);
      tick();
    end

    // -- reset while a read is in flight --
    req = 2'b01; we = 2'b00; addr[0] = 32'h28;
    @(negedge clk);
    chk("midrst_gnt", 64'(gnt[0]), 64'h1);
    tick();
    rst_n = 1'b0; req = 2'b11;
    @(negedge clk);
    chk("midrst_low_gnt",    64'(gnt[0]), 64'h0);
    chk("midrst_low_sreq",   64'(sreq[0]), 64'h0);
    chk("midrst_low_rvalid", 64'(rvalid[0]), 64'h0);
    chk("midrst_low_rdata",  rdata[0][0], 64'h0);
    tick();
    rst_n = 1'b1; req = 2'b00;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("midrst_after%0d_rvalid", k), 64'(rvalid[0]), 64'h0);
      if (k == 0) chk("midrst_cnt_cleared", 64'(ccnt[0]), 64'h0);
      tick();
    end
    // Priority was left pointing at port 1; reset must return it to port 0.
    req = 2'b11; we = 2'b00; addr[0] = 32'h28; addr[1] = 32'h28;
    @(negedge clk);
    chk("midrst_prio_reset", 64'(gnt[0]), 64'h1);
    tick();
    req = 2'b00;
    repeat (3) tick();

    // -- latency sweep with random traffic against a scoreboard --
    rst_n = 1'b0; load_en = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1; load_en = 1'b0;
    for (int i = 0; i < NW; i++) shadow[i] = init_word(i);
    for (int d = 0; d < 3; d++)
      for (int s = 0; s < 8; s++) begin
        ring_v[d][s] = 1'b0; ring_p[d][s] = 1'b0; ring_d[d][s] = '0;
      end
    prio_m = 1'b0;

    for (int cyc = 0; cyc < 308; cyc++) begin
      if (cyc < 300) begin
        req = 2'($urandom_range(0, 3));
        we  = 2'($urandom_range(0, 3));
        for (int q = 0; q < 2; q++) begin
          addr[q]  = 32'($urandom_range(0, 15) * 8 + $urandom_range(0, 7));
          wdata[q] = {$urandom, $urandom};
          strb[q]  = 8'($urandom_range(0, 255));
        end
      end else begin
        req = 2'b00;
      end
      @(negedge clk);
      eg = (req == 2'b11) ? (prio_m ? 2'b10 : 2'b01) : req;
      slot = cyc % 8;
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("rnd_L%0d_c%0d_gnt", lat(d), cyc), 64'(gnt[d]), 64'(eg));
        chk($sformatf("rnd_L%0d_c%0d_rvalid", lat(d), cyc), 64'(rvalid[d]),
            ring_v[d][slot] ? (ring_p[d][slot] ? 64'h2 : 64'h1) : 64'h0);
        chk($sformatf("rnd_L%0d_c%0d_rdata0", lat(d), cyc), rdata[d][0],
            (ring_v[d][slot] && !ring_p[d][slot]) ? ring_d[d][slot] : 64'h0);
        chk($sformatf("rnd_L%0d_c%0d_rdata1", lat(d), cyc), rdata[d][1],
            (ring_v[d][slot] && ring_p[d][slot]) ? ring_d[d][slot] : 64'h0);
        ring_v[d][slot] = 1'b0;
      end
      if (eg != 2'b00) begin
        p   = eg[1] ? 1 : 0;
        a   = addr[p];
        w   = a[12:3];
        dat = we[p] ? 64'h0 : shadow[w];
        for (int d = 0; d < 3; d++) begin
          ring_v[d][(cyc + lat(d)) % 8] = 1'b1;
          ring_p[d][(cyc + lat(d)) % 8] = eg[1];
          ring_d[d][(cyc + lat(d)) % 8] = dat;
        end
        if (we[p])
          for (int b = 0; b < 8; b++)
            if (strb[p][b]) shadow[w][8*b +: 8] = wdata[p][8*b +: 8];
      end
      if (req == 2'b11) prio_m = ~prio_m;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
